// File: rtl/cache_fill_fsm.sv
// Cache miss block fill: latches the 16-byte block base on a miss, issues eight
// word reads back to back, and writes returned words into the data array, then the tag.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [15:0]           memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  memory_enable,
  output logic                  memory_wr,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [2:0]            cache_word_index,
  output logic [15:0]           cache_data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [3:0]            issue_cnt_q, issue_cnt_d;
  logic [3:0]            recv_cnt_q, recv_cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;

  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    base_d           = base_q;
    memory_enable    = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_word_index = '0;
    cache_data       = '0;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          // Masking the low nibble aligns the base to the 16-byte block.
          base_d      = miss_address & ~ADDR_WIDTH'(4'hF);
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end
      FILL: begin
        memory_enable = (issue_cnt_q < 4'd8);
        if (memory_enable) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          cache_word_index = recv_cnt_q[2:0];
          cache_data       = memory_data;
          recv_cnt_d       = recv_cnt_q + 4'd1;
          if (recv_cnt_q == 4'd7) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
    end
  end

  assign fsm_busy       = (state_q == FILL);
  assign memory_wr      = 1'b0;
  assign memory_address = base_q + {{(ADDR_WIDTH-5){1'b0}}, issue_cnt_q, 1'b0};

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: single fill, held miss, back-to-back fills,
// reset mid-fill with stale returns, and valid pulses while idle.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_enable;
  logic        memory_wr;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  cache_word_index;
  logic [15:0] cache_data;

  int n_checks = 0;
  int n_fails  = 0;

  cache_fill_fsm #(.ADDR_WIDTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_enable     (memory_enable),
    .memory_wr         (memory_wr),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .cache_word_index  (cache_word_index),
    .cache_data        (cache_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, fsm_busy, 1'b0);
    check({tag, "_en"}, memory_enable, 1'b0);
    check({tag, "_wr"}, memory_wr, 1'b0);
    check({tag, "_wda"}, write_data_array, 1'b0);
    check({tag, "_wta"}, write_tag_array, 1'b0);
    check({tag, "_idx"}, cache_word_index, 3'd0);
    check({tag, "_data"}, cache_data, 16'h0);
  endtask

  // Entered at the start of cycle 1 (edge 0 sampled the miss); leaves at the start of cycle 13.
  task automatic run_fill(input logic [15:0] base, input logic [15:0] seed,
                          input logic hold_miss, input logic [15:0] hold_addr);
    for (int c = 1; c <= 12; c++) begin
      logic v;
      v = (c >= 5);
      miss_detected     = hold_miss;
      miss_address      = hold_addr;
      memory_data_valid = v;
      memory_data       = v ? seed + 16'(c - 5) : 16'hDEAD;
      #1;
      check("busy", fsm_busy, 1'b1);
      check("en", memory_enable, (c <= 8));
      if (c <= 8) check("addr", memory_address, base + 16'(2 * (c - 1)));
      check("wr", memory_wr, 1'b0);
      check("wda", write_data_array, v);
      check("idx", cache_word_index, v ? 3'(c - 5) : 3'd0);
      check("data", cache_data, v ? seed + 16'(c - 5) : 16'h0);
      check("wta", write_tag_array, (c == 12));
      tick();
    end
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
  endtask

  initial begin
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data       = 16'h0;
    memory_data_valid = 1'b0;

    // Reset state
    tick();
    check_quiet("rst");
    check("rst_addr", memory_address, 16'h0);
    rst = 1'b0;
    tick();

    // Single miss at 0x1236
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    tick();
    run_fill(16'h1230, 16'hA000, 1'b0, 16'h1236);
    miss_detected = 1'b0;
    #1;
    check_quiet("c13");
    tick();

    // Valid while idle is ignored
    for (int i = 0; i < 3; i++) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hBEEF;
      #1;
      check_quiet("idle_valid");
      tick();
    end
    memory_data_valid = 1'b0;

    // Miss held during fill with changed address; second fill follows
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    tick();
    run_fill(16'h1230, 16'h3300, 1'b1, 16'h5550);
    #1;
    check("hold_c13_busy", fsm_busy, 1'b0);
    check("hold_c13_wta", write_tag_array, 1'b0);
    tick();
    run_fill(16'h5550, 16'h4400, 1'b0, 16'h5550);
    #1;
    check("second_done_busy", fsm_busy, 1'b0);
    tick();

    // Back-to-back misses at 0x0000 then 0xFFF0
    miss_detected = 1'b1;
    miss_address  = 16'h0000;
    tick();
    run_fill(16'h0000, 16'h1100, 1'b0, 16'h0000);
    miss_detected = 1'b1;
    miss_address  = 16'hFFF0;
    #1;
    check("b2b_c13_busy", fsm_busy, 1'b0);
    tick();
    run_fill(16'hFFF0, 16'h2200, 1'b0, 16'hFFF0);
    #1;
    check("b2b_done_busy", fsm_busy, 1'b0);
    tick();

    // Reset in cycle 6 of a fill, then stale valid words
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    tick();
    miss_detected = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      memory_data_valid = (c >= 5);
      memory_data       = 16'hC000;
      #1;
      check("pre_rst_busy", fsm_busy, 1'b1);
      check("pre_rst_addr", memory_address, 16'h1230 + 16'(2 * (c - 1)));
      tick();
    end
    memory_data_valid = 1'b1;
    memory_data       = 16'hC001;
    #1;
    check("c6_wda", write_data_array, 1'b1);
    check("c6_idx", cache_word_index, 3'd1);
    rst = 1'b1;
    #1;
    check_quiet("async_rst");
    check("async_rst_addr", memory_address, 16'h0);
    tick();
    rst = 1'b0;
    for (int c = 7; c <= 12; c++) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hC000 + 16'(c - 5);
      #1;
      check_quiet("stale");
      tick();
    end
    memory_data_valid = 1'b0;
    #1;
    check_quiet("post_stale");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
